// File: rtl/spram_boot_seq_pkg.sv
// Shared definitions for the SPRAM boot sequencer: state encoding,
// flash header layout and the default flash image locations.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    DATA    = 3'd2,
    FLUSH   = 3'd3,
    WAIT_IP = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } boot_state_e;

  // Default flash byte addresses of the two SPRAM bank images
  localparam logic [23:0] DEF_IMG0_ADDR = 24'h030000;
  localparam logic [23:0] DEF_IMG1_ADDR = 24'h050000;

  // Image header: the word count sits in the low half of the first word
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_MSB = 15;
  localparam int LEN_W       = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  // SPRAM word address width and number of flush cycles between images
  localparam int ADDR_W    = 14;
  localparam int FLUSH_CYC = 2;

  // Extract the image length field from a header word
  function automatic logic [LEN_W-1:0] hdr_len(input logic [31:0] word);
    return word[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage

// File: rtl/spram_boot_seq_if.sv
// SPI flash FIFO link between the boot sequencer (master) and the FIFO (slave).
interface spram_boot_seq_if;

  logic [23:0] fifo_addr_o;
  logic        fifo_fill_o;
  logic        fifo_flush_o;
  logic        fifo_valid_i;
  logic [31:0] fifo_data_i;

  modport master (
    output fifo_addr_o,
    output fifo_fill_o,
    output fifo_flush_o,
    input  fifo_valid_i,
    input  fifo_data_i
  );

  modport slave (
    input  fifo_addr_o,
    input  fifo_fill_o,
    input  fifo_flush_o,
    output fifo_valid_i,
    output fifo_data_i
  );

endinterface

// File: rtl/spram_boot_seq_tmo.sv
// Idle-cycle watchdog: counts consecutive tick cycles and flags expiry on the
// CYC-th one. Clear has priority and restarts the count from zero.
module boot_tmo #(
  parameter int unsigned CYC = 1048576
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(CYC + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Expiry depends only on the stored count so it never loops back through clear
  assign expire_o = tick_i && (cnt_q == W'(CYC - 1));

  // Next count: clear wins, otherwise advance on every idle tick
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spram_boot_seq.sv
// SPRAM boot sequencer: copies two length-prefixed images from SPI flash into
// SPRAM banks 0 and 1, waits for hard-IP configuration, then releases the SoC.
module spram_boot_seq
  import boot_pkg::*;
#(
  parameter logic [23:0] IMG0_ADDR = DEF_IMG0_ADDR,
  parameter logic [23:0] IMG1_ADDR = DEF_IMG1_ADDR,
  parameter int unsigned MAX_WORDS = 16384,
  parameter int unsigned TMO_CYC   = 1048576
) (
  input  logic               clk_i,
  input  logic               rst_i,
  spram_boot_seq_if.master   fifo,
  output logic [ADDR_W-1:0]  ld_addr_o,
  output logic [31:0]        ld_data_o,
  output logic [1:0]         ld_we_o,
  output logic [1:0]         ld_own_o,
  input  logic               ip_done_i,
  output logic               soc_rst_o,
  output logic               done_o,
  output logic               err_o
);

  boot_state_e      state_q, state_d;
  logic             img_q, img_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] wcnt_q, wcnt_d;
  logic [1:0]       fcnt_q, fcnt_d;

  logic             loading;
  logic             tmo_clear;
  logic             tmo_expire;
  logic [LEN_W-1:0] hlen;

  // The watchdog only runs while waiting on the FIFO; a word or a state change restarts it
  assign loading   = (state_q == HDR) || (state_q == DATA);
  assign tmo_clear = fifo.fifo_valid_i || !loading || (state_d != state_q);
  assign hlen      = hdr_len(fifo.fifo_data_i);
  assign ld_data_o = fifo.fifo_data_i;

  boot_tmo #(
    .CYC (TMO_CYC)
  ) u_tmo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (tmo_clear),
    .tick_i   (loading && !fifo.fifo_valid_i),
    .expire_o (tmo_expire)
  );

  // Next-state and output decode; SPRAM writes are combinational on the FIFO word
  always_comb begin
    state_d           = state_q;
    img_d             = img_q;
    len_d             = len_q;
    wcnt_d            = wcnt_q;
    fcnt_d            = fcnt_q;
    fifo.fifo_addr_o  = img_q ? IMG1_ADDR : IMG0_ADDR;
    fifo.fifo_fill_o  = 1'b0;
    fifo.fifo_flush_o = 1'b0;
    ld_addr_o         = wcnt_q[ADDR_W-1:0];
    ld_we_o           = 2'b00;
    ld_own_o          = 2'b11;
    soc_rst_o         = 1'b1;
    done_o            = 1'b0;
    err_o             = 1'b0;

    unique case (state_q)
      IDLE: begin
        fifo.fifo_flush_o = 1'b1;
        img_d             = 1'b0;
        wcnt_d            = '0;
        state_d           = HDR;
      end
      HDR: begin
        fifo.fifo_fill_o = 1'b1;
        if (fifo.fifo_valid_i) begin
          if ((hlen == '0) || ({16'd0, hlen} > MAX_WORDS)) begin
            state_d = ERR;
          end else begin
            len_d   = hlen;
            wcnt_d  = '0;
            state_d = DATA;
          end
        end else if (tmo_expire) begin
          state_d = ERR;
        end
      end
      DATA: begin
        fifo.fifo_fill_o = 1'b1;
        if (fifo.fifo_valid_i) begin
          ld_we_o = img_q ? 2'b10 : 2'b01;
          wcnt_d  = wcnt_q + 1'b1;
          if (wcnt_q == len_q - 1'b1) begin
            fcnt_d  = '0;
            state_d = FLUSH;
          end
        end else if (tmo_expire) begin
          state_d = ERR;
        end
      end
      FLUSH: begin
        fifo.fifo_flush_o = 1'b1;
        fcnt_d            = fcnt_q + 1'b1;
        if (fcnt_q == 2'(FLUSH_CYC - 1)) begin
          if (!img_q) begin
            img_d   = 1'b1;
            state_d = HDR;
          end else begin
            state_d = WAIT_IP;
          end
        end
      end
      WAIT_IP: begin
        if (ip_done_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ld_own_o  = 2'b00;
        soc_rst_o = 1'b0;
        done_o    = 1'b1;
      end
      ERR: begin
        fifo.fifo_flush_o = 1'b1;
        err_o             = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and load bookkeeping registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      img_q   <= 1'b0;
      len_q   <= '0;
      wcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      img_q   <= img_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_spram_boot_seq.sv
// Directed bench for the SPRAM boot sequencer, run with a 16-cycle watchdog.
module tb_spram_boot_seq;
  import boot_pkg::*;

  localparam logic [23:0] A0 = 24'h030000;
  localparam logic [23:0] A1 = 24'h050000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ip_done_i = 1'b0;
  logic [13:0] ld_addr_o;
  logic [31:0] ld_data_o;
  logic [1:0]  ld_we_o;
  logic [1:0]  ld_own_o;
  logic        soc_rst_o;
  logic        done_o;
  logic        err_o;

  int vec_cnt = 0;
  int miss_cnt = 0;
  int cyc = 0;
  int wr0 = 0;
  int wr1 = 0;
  int badwe = 0;
  logic cap_clear = 1'b1;
  logic [31:0] cap0 [0:15];
  logic [31:0] cap1 [0:15];

  spram_boot_seq_if fifo ();

  spram_boot_seq #(
    .IMG0_ADDR (A0),
    .IMG1_ADDR (A1),
    .MAX_WORDS (16384),
    .TMO_CYC   (16)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .fifo      (fifo.master),
    .ld_addr_o (ld_addr_o),
    .ld_data_o (ld_data_o),
    .ld_we_o   (ld_we_o),
    .ld_own_o  (ld_own_o),
    .ip_done_i (ip_done_i),
    .soc_rst_o (soc_rst_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  // Cycle count since the last reset release
  always @(posedge clk_i) cyc <= rst_i ? 0 : cyc + 1;

  // Record every SPRAM write mid-cycle into per-bank shadow memories
  always @(negedge clk_i) begin
    if (cap_clear) begin
      for (int i = 0; i < 16; i++) begin
        cap0[i] = 'x;
        cap1[i] = 'x;
      end
      wr0 = 0;
      wr1 = 0;
      badwe = 0;
    end else if (!rst_i) begin
      if (ld_we_o == 2'b11) badwe++;
      if (ld_we_o[0]) begin
        wr0++;
        if (ld_addr_o < 14'd16) cap0[ld_addr_o[3:0]] = ld_data_o;
      end
      if (ld_we_o[1]) begin
        wr1++;
        if (ld_addr_o < 14'd16) cap1[ld_addr_o[3:0]] = ld_data_o;
      end
    end
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    fifo.fifo_valid_i = 1'b0;
    fifo.fifo_data_i = '0;
    ip_done_i = 1'b0;
    cap_clear = 1'b1;
    cycle();
    cycle();
    cap_clear = 1'b0;
    rst_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    fifo.fifo_valid_i = 1'b1;
    fifo.fifo_data_i = w;
    cycle();
    fifo.fifo_valid_i = 1'b0;
    fifo.fifo_data_i = '0;
  endtask

  task automatic wait_fill(input logic [23:0] exp_addr, input string nm);
    int n = 0;
    while (!fifo.fifo_fill_o && n < 8) begin
      cycle();
      n++;
    end
    vec_cnt++; if (fifo.fifo_fill_o !== 1'b1) begin miss_cnt++; $display("[TB] FAIL %s_fill got %b exp 1 (bounded wait expired)", nm, fifo.fifo_fill_o); end
    vec_cnt++; if (fifo.fifo_addr_o !== exp_addr) begin miss_cnt++; $display("[TB] FAIL %s_addr got %h exp %h", nm, fifo.fifo_addr_o, exp_addr); end
  endtask

  // Outputs held in reset, then exactly one IDLE cycle before the first fetch
  task automatic test_reset();
    rst_i = 1'b1;
    fifo.fifo_valid_i = 1'b0;
    fifo.fifo_data_i = '0;
    cycle();
    cycle();
    vec_cnt++; if (fifo.fifo_flush_o !== 1'b1) begin miss_cnt++; $display("[TB] FAIL rst_flush got %b exp 1", fifo.fifo_flush_o); end
    vec_cnt++; if (fifo.fifo_fill_o !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_fill got %b exp 0", fifo.fifo_fill_o); end
    vec_cnt++; if (ld_own_o !== 2'b11) begin miss_cnt++; $display("[TB] FAIL rst_own got %b exp 11", ld_own_o); end
    vec_cnt++; if (ld_we_o !== 2'b00) begin miss_cnt++; $display("[TB] FAIL rst_we got %b exp 00", ld_we_o); end
    vec_cnt++; if ({soc_rst_o, done_o, err_o} !== 3'b100) begin miss_cnt++; $display("[TB] FAIL rst_status got %b exp 100", {soc_rst_o, done_o, err_o}); end
    vec_cnt++; if (ld_addr_o !== 14'd0) begin miss_cnt++; $display("[TB] FAIL rst_addr got %0d exp 0", ld_addr_o); end
    cap_clear = 1'b0;
    rst_i = 1'b0;
    cycle();
    vec_cnt++; if ({fifo.fifo_fill_o, fifo.fifo_flush_o} !== 2'b10) begin miss_cnt++; $display("[TB] FAIL first_hdr fill/flush got %b exp 10", {fifo.fifo_fill_o, fifo.fifo_flush_o}); end
    vec_cnt++; if (fifo.fifo_addr_o !== A0) begin miss_cnt++; $display("[TB] FAIL first_hdr_addr got %h exp %h", fifo.fifo_addr_o, A0); end
  endtask

  // Two-image boot followed by hard-IP completion and SoC release
  task automatic test_normal_boot();
    logic [31:0] a [0:3];
    logic [31:0] b [0:1];
    int n;
    a[0] = 32'h1111_0000; a[1] = 32'h2222_0001; a[2] = 32'h3333_0002; a[3] = 32'h4444_0003;
    b[0] = 32'hB0B0_0000; b[1] = 32'hB1B1_0001;
    apply_reset();
    wait_fill(A0, "nb_img0");
    send(32'd4);
    send(a[0]);
    send(a[1]);
    fifo.fifo_valid_i = 1'b1;
    fifo.fifo_data_i = a[2];
    #1;
    vec_cnt++; if ({ld_we_o, ld_addr_o, ld_data_o} !== {2'b01, 14'd2, a[2]}) begin miss_cnt++; $display("[TB] FAIL nb_comb_write we/addr/data got %b/%0d/%h exp 01/2/%h", ld_we_o, ld_addr_o, ld_data_o, a[2]); end
    cycle();
    send(a[3]);
    vec_cnt++; if ({fifo.fifo_flush_o, fifo.fifo_fill_o} !== 2'b10) begin miss_cnt++; $display("[TB] FAIL nb_flush1 got %b exp 10", {fifo.fifo_flush_o, fifo.fifo_fill_o}); end
    cycle();
    vec_cnt++; if (fifo.fifo_flush_o !== 1'b1) begin miss_cnt++; $display("[TB] FAIL nb_flush2 got %b exp 1", fifo.fifo_flush_o); end
    cycle();
    vec_cnt++; if ({fifo.fifo_flush_o, fifo.fifo_fill_o} !== 2'b01) begin miss_cnt++; $display("[TB] FAIL nb_after_flush got %b exp 01", {fifo.fifo_flush_o, fifo.fifo_fill_o}); end
    vec_cnt++; if (fifo.fifo_addr_o !== A1) begin miss_cnt++; $display("[TB] FAIL nb_img1_addr got %h exp %h", fifo.fifo_addr_o, A1); end
    send(32'd2);
    send(b[0]);
    send(b[1]);
    cycle();
    cycle();
    vec_cnt++; if ({fifo.fifo_fill_o, fifo.fifo_flush_o, soc_rst_o, done_o, ld_own_o} !== 6'b001011) begin miss_cnt++; $display("[TB] FAIL nb_wait_ip fill/flush/soc/done/own got %b exp 001011", {fifo.fifo_fill_o, fifo.fifo_flush_o, soc_rst_o, done_o, ld_own_o}); end
    n = 0;
    while (cyc < 50 && n < 100) begin
      cycle();
      n++;
    end
    vec_cnt++; if (soc_rst_o !== 1'b1) begin miss_cnt++; $display("[TB] FAIL nb_soc_before_ip got %b exp 1", soc_rst_o); end
    ip_done_i = 1'b1;
    cycle();
    ip_done_i = 1'b0;
    vec_cnt++; if ({done_o, soc_rst_o, ld_own_o, err_o} !== 5'b10000) begin miss_cnt++; $display("[TB] FAIL nb_done done/soc/own/err got %b exp 10000", {done_o, soc_rst_o, ld_own_o, err_o}); end
    cycle();
    cycle();
    cycle();
    vec_cnt++; if ({done_o, soc_rst_o} !== 2'b10) begin miss_cnt++; $display("[TB] FAIL nb_done_sticky got %b exp 10", {done_o, soc_rst_o}); end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if (cap0[i] !== a[i]) begin miss_cnt++; $display("[TB] FAIL nb_bank0[%0d] got %h exp %h", i, cap0[i], a[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      vec_cnt++; if (cap1[i] !== b[i]) begin miss_cnt++; $display("[TB] FAIL nb_bank1[%0d] got %h exp %h", i, cap1[i], b[i]); end
    end
    vec_cnt++; if ({wr0, wr1, badwe} !== {32'd4, 32'd2, 32'd0}) begin miss_cnt++; $display("[TB] FAIL nb_write_counts got %0d/%0d/%0d exp 4/2/0", wr0, wr1, badwe); end
  endtask

  // All-ones data is ordinary data and must not end the image early
  task automatic test_ffff_data();
    apply_reset();
    cycle();
    send(32'd3);
    send(32'hFFFF_FFFF);
    vec_cnt++; if ({fifo.fifo_fill_o, fifo.fifo_flush_o} !== 2'b10) begin miss_cnt++; $display("[TB] FAIL ff_no_early_end got %b exp 10", {fifo.fifo_fill_o, fifo.fifo_flush_o}); end
    send(32'd1);
    send(32'd2);
    vec_cnt++; if (fifo.fifo_flush_o !== 1'b1) begin miss_cnt++; $display("[TB] FAIL ff_flush got %b exp 1", fifo.fifo_flush_o); end
    vec_cnt++; if ({cap0[0], cap0[1], cap0[2]} !== {32'hFFFF_FFFF, 32'd1, 32'd2}) begin miss_cnt++; $display("[TB] FAIL ff_bank0 got %h %h %h exp ffffffff 1 2", cap0[0], cap0[1], cap0[2]); end
    vec_cnt++; if (wr0 !== 3) begin miss_cnt++; $display("[TB] FAIL ff_wr0 got %0d exp 3", wr0); end
  endtask

  // Zero and oversize headers go to a sticky error; the largest legal size loads
  task automatic test_bad_header();
    logic [31:0] hdrs [0:1];
    hdrs[0] = 32'd0;
    hdrs[1] = 32'd16385;
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      cycle();
      send(hdrs[k]);
      vec_cnt++; if ({err_o, fifo.fifo_flush_o, fifo.fifo_fill_o, soc_rst_o, done_o} !== 5'b11010) begin miss_cnt++; $display("[TB] FAIL bad_hdr%0d err/flush/fill/soc/done got %b exp 11010", k, {err_o, fifo.fifo_flush_o, fifo.fifo_fill_o, soc_rst_o, done_o}); end
      send(32'h1234_5678);
      send(32'd2);
      cycle();
      vec_cnt++; if ({err_o, ld_own_o} !== 3'b111) begin miss_cnt++; $display("[TB] FAIL bad_hdr%0d_sticky err/own got %b exp 111", k, {err_o, ld_own_o}); end
      vec_cnt++; if (wr0 + wr1 !== 0) begin miss_cnt++; $display("[TB] FAIL bad_hdr%0d_writes got %0d exp 0", k, wr0 + wr1); end
    end
    apply_reset();
    cycle();
    send(32'd16384);
    vec_cnt++; if ({err_o, fifo.fifo_fill_o} !== 2'b01) begin miss_cnt++; $display("[TB] FAIL max_hdr err/fill got %b exp 01", {err_o, fifo.fifo_fill_o}); end
    send(32'hCAFE_0000);
    vec_cnt++; if ({wr0, cap0[0]} !== {32'd1, 32'hCAFE_0000}) begin miss_cnt++; $display("[TB] FAIL max_hdr_write got %0d/%h exp 1/cafe0000", wr0, cap0[0]); end
  endtask

  // Words beyond the header length are dropped during the flush
  task automatic test_extra_words();
    apply_reset();
    cycle();
    send(32'hFFFF_0002);
    send(32'hC000_0000);
    send(32'hC000_0001);
    fifo.fifo_valid_i = 1'b1;
    fifo.fifo_data_i = 32'hC000_0002;
    #1;
    vec_cnt++; if ({ld_we_o, fifo.fifo_flush_o, fifo.fifo_fill_o} !== 4'b0010) begin miss_cnt++; $display("[TB] FAIL xw_flush1 we/flush/fill got %b exp 0010", {ld_we_o, fifo.fifo_flush_o, fifo.fifo_fill_o}); end
    cycle();
    fifo.fifo_data_i = 32'hC000_0003;
    #1;
    vec_cnt++; if ({ld_we_o, fifo.fifo_flush_o, fifo.fifo_fill_o} !== 4'b0010) begin miss_cnt++; $display("[TB] FAIL xw_flush2 we/flush/fill got %b exp 0010", {ld_we_o, fifo.fifo_flush_o, fifo.fifo_fill_o}); end
    cycle();
    fifo.fifo_data_i = 32'hC000_0004;
    #1;
    vec_cnt++; if ({ld_we_o, fifo.fifo_flush_o, fifo.fifo_fill_o} !== 4'b0001) begin miss_cnt++; $display("[TB] FAIL xw_img1_hdr we/flush/fill got %b exp 0001", {ld_we_o, fifo.fifo_flush_o, fifo.fifo_fill_o}); end
    vec_cnt++; if (fifo.fifo_addr_o !== A1) begin miss_cnt++; $display("[TB] FAIL xw_img1_addr got %h exp %h", fifo.fifo_addr_o, A1); end
    cycle();
    fifo.fifo_valid_i = 1'b0;
    vec_cnt++; if ({wr0, wr1, cap0[0], cap0[1]} !== {32'd2, 32'd0, 32'hC000_0000, 32'hC000_0001}) begin miss_cnt++; $display("[TB] FAIL xw_writes got %0d/%0d %h %h exp 2/0 c0000000 c0000001", wr0, wr1, cap0[0], cap0[1]); end
  endtask

  // FIFO stall in DATA trips the watchdog on the 16th idle cycle; reset recovers
  task automatic test_timeout();
    apply_reset();
    cycle();
    send(32'd4);
    send(32'hD000_0000);
    for (int i = 0; i < 15; i++) cycle();
    vec_cnt++; if ({err_o, fifo.fifo_fill_o} !== 2'b01) begin miss_cnt++; $display("[TB] FAIL tmo_15 err/fill got %b exp 01", {err_o, fifo.fifo_fill_o}); end
    cycle();
    vec_cnt++; if ({err_o, fifo.fifo_flush_o, fifo.fifo_fill_o} !== 3'b110) begin miss_cnt++; $display("[TB] FAIL tmo_16 err/flush/fill got %b exp 110", {err_o, fifo.fifo_flush_o, fifo.fifo_fill_o}); end
    rst_i = 1'b1;
    cap_clear = 1'b1;
    cycle();
    cap_clear = 1'b0;
    rst_i = 1'b0;
    vec_cnt++; if ({err_o, fifo.fifo_flush_o, ld_own_o} !== 4'b0111) begin miss_cnt++; $display("[TB] FAIL tmo_rst err/flush/own got %b exp 0111", {err_o, fifo.fifo_flush_o, ld_own_o}); end
    wait_fill(A0, "tmo_reload0");
    send(32'd1);
    send(32'hE000_0000);
    cycle();
    cycle();
    wait_fill(A1, "tmo_reload1");
    send(32'd1);
    send(32'hF000_0000);
    cycle();
    cycle();
    ip_done_i = 1'b1;
    cycle();
    ip_done_i = 1'b0;
    vec_cnt++; if ({done_o, err_o, soc_rst_o} !== 3'b100) begin miss_cnt++; $display("[TB] FAIL tmo_reload_done done/err/soc got %b exp 100", {done_o, err_o, soc_rst_o}); end
    vec_cnt++; if ({cap0[0], cap1[0]} !== {32'hE000_0000, 32'hF000_0000}) begin miss_cnt++; $display("[TB] FAIL tmo_reload_data got %h %h exp e0000000 f0000000", cap0[0], cap1[0]); end
  endtask

  // Reset in the middle of the second image returns to IDLE and restarts at image 0
  task automatic test_reset_mid_load();
    apply_reset();
    cycle();
    send(32'd2);
    send(32'h6000_0000);
    send(32'h6000_0001);
    cycle();
    cycle();
    send(32'd4);
    send(32'h7000_0000);
    vec_cnt++; if ({wr1, fifo.fifo_fill_o} !== {32'd1, 1'b1}) begin miss_cnt++; $display("[TB] FAIL mid_pre wr1/fill got %0d/%b exp 1/1", wr1, fifo.fifo_fill_o); end
    rst_i = 1'b1;
    cycle();
    vec_cnt++; if ({fifo.fifo_flush_o, fifo.fifo_fill_o, ld_own_o, ld_we_o, err_o, soc_rst_o} !== 8'b10110001) begin miss_cnt++; $display("[TB] FAIL mid_rst flush/fill/own/we/err/soc got %b exp 10110001", {fifo.fifo_flush_o, fifo.fifo_fill_o, ld_own_o, ld_we_o, err_o, soc_rst_o}); end
    rst_i = 1'b0;
    cycle();
    vec_cnt++; if ({fifo.fifo_fill_o, fifo.fifo_addr_o} !== {1'b1, A0}) begin miss_cnt++; $display("[TB] FAIL mid_restart fill/addr got %b/%h exp 1/%h", fifo.fifo_fill_o, fifo.fifo_addr_o, A0); end
  endtask

  // Scenario sequence and summary
  initial begin
    fifo.fifo_valid_i = 1'b0;
    fifo.fifo_data_i = '0;
    test_reset();
    test_normal_boot();
    test_ffff_data();
    test_bad_header();
    test_extra_words();
    test_timeout();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
